mem_data_arbiter: RTL and testbench
===================================

Name: mem_data_arbiter

Overview:
- Two-requester arbiter in front of the 256x32 data memory.
- Port 0 is the CPU load/store unit; port 1 is the DMA/program-loader.
- Muxes one access per cycle onto the memory's wr/addr/data_in, captures read data, and returns it with a one-cycle valid.
- Round-robin with a bounded burst, so neither port starves the other.

Parameters:
- AW, 8, memory address width.
- DW, 32, data width.
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting; legal range 1..15.
- FIRST_PORT, 0, port that wins a simultaneous request out of reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  access request; held with its command until granted.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  AW each  word address.
- wdata0, wdata1  in  DW each  write data, signed.
- gnt0, gnt1  out  1 each  combinational grant; the access completes at the next rising edge.
- rvalid0, rvalid1  out  1 each  registered one-cycle pulse; rdataN is valid.
- rdata0, rdata1  out  DW each  registered read data, signed.
- mem_wr  out  1  to memory wr.
- mem_addr  out  AW  to memory addr.
- mem_wdata  out  DW  to memory data_in.
- mem_rdata  in  DW  from memory data_out (combinational read).

Behaviour:
Reset:
- While rst_n = 0: state IDLE, burst count 0, last-served = !FIRST_PORT.
- rvalid0/1 = 0, rdata0/1 = 0.
- gnt0/1 forced to 0 and mem_wr forced to 0 (gated by rst_n); mem_addr and mem_wdata = 0.
- Reset asserted mid-access: any write not yet clocked is dropped; a pending rvalid is cleared.

States: IDLE, OWN0, OWN1. Owner selection, evaluated combinationally from the current state and the requests:
- OWNn and reqn=1 and (other port idle or count < MAX_BURST) -> grant n.
- OWNn and other port requesting and (reqn=0 or count = MAX_BURST) -> grant other.
- IDLE, one request -> grant that port.
- IDLE, both requesting -> grant !last-served.
- No request -> no grant; next state IDLE, count 0.

At each rising edge:
- state <= OWN(granted port).
- count <= count+1 when the same owner is kept, 1 on a switch, saturating at MAX_BURST.
- last-served <= granted port.

Grant and memory drive:
- At most one gnt high per cycle, never both.
- mem_addr, mem_wdata and mem_wr = granted port's addr, wdata and (we & gnt). With no grant: mem_wr = 0, addr and wdata hold port 0's values.

Read path:
- Read granted in cycle T: rdataN <= mem_rdata at the edge ending T; rvalidN = 1 for cycle T+1 only.
- Back-to-back granted reads give rvalid high on consecutive cycles.
- rdataN holds its value until the next read by the same port.

Write path:
- Write granted in cycle T commits at the edge ending T. No rvalid is produced.
- A read to the same address by either port granted in T+1 returns the new data.

Handshake:
- A requester keeps req/we/addr/wdata stable until it samples gnt=1 at an edge.
- It may drop req or change its command in the cycle after the grant.
- An ungranted request has no side effects.

Latency:
- Uncontended: grant in the same cycle as req; read data one cycle later.
- Worst-case wait under contention: MAX_BURST cycles.

Decomposition:
- Shared package: arbiter state encoding (IDLE/OWN0/OWN1), port index constants PORT_CPU=0 and PORT_DMA=1, and AW/DW defaults shared with the memory.
- One natural sub-module: mem_arb_rr_pick, the combinational next-owner and burst logic. The read-return registers stay in the top.

Test Plan:
- Reset release with req0=1, we0=1, addr0=8'h10, wdata0=32'h0000_00AA -> gnt0=1 that cycle; then a read of 8'h10 gives rvalid0 one cycle later with rdata0=32'h0000_00AA.
- req0 and req1 both held continuously with reads, MAX_BURST=4, FIRST_PORT=0 -> grant sequence 0,0,0,0,1,1,1,1,0...; never both gnt; each rvalid pulse is aligned one cycle after its grant.
- Port 1 writes 32'hFFFF_FFFF (-1) to 8'hFF in cycle T; port 0 reads 8'hFF in T+1 -> rdata0=32'hFFFF_FFFF, rvalid0 in T+2.
- Port 0 alone issues 10 consecutive reads of addresses 0..9 -> gnt0 high for all 10 cycles (no cap without contention); rdata0 follows mem[0..9] with 1-cycle latency.
- rst_n pulled low while a port 1 write to 8'h20 is pending but ungranted, and a port 0 rvalid is pending -> gnt/mem_wr/rvalid drop to 0 immediately; mem[8'h20] is unchanged; after release the first simultaneous request is granted to FIRST_PORT.
- Port 1 requests while port 0 holds a burst at count=2 and then drops req0 -> port 1 is granted the next cycle (no idle bubble); count restarts at 1.

Source files
------------

// File: rtl/mem_data_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter:
// state encoding, port indices and memory geometry.
package mem_data_arbiter_pkg;

   localparam int ARB_AW = 8;
   localparam int ARB_DW = 32;
   localparam int CNT_W  = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef struct packed {
      logic valid;
      logic port;
   } grant_t;

   function automatic logic [1:0] own_state(input logic port);
      return port ? ST_OWN1 : ST_OWN0;
   endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Next-owner selection and burst counting for the
// two-port data-memory arbiter (purely combinational).
module mem_arb_rr_pick
   import mem_data_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic [1:0]       state,
   input  logic [CNT_W-1:0] count,
   input  logic             last,
   input  logic             req0,
   input  logic             req1,
   output grant_t           gnt,
   output logic [1:0]       state_nx,
   output logic [CNT_W-1:0] count_nx
);

   localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_BURST);

   logic cap;
   logic kept;

   assign cap = (count >= MAXC);

   always_comb begin
      gnt = '0;
      unique case (1'b1)
         (state == ST_OWN0): begin
            if (req0 && (!req1 || !cap))
               gnt = '{valid: 1'b1, port: PORT_CPU};
            else if (req1)
               gnt = '{valid: 1'b1, port: PORT_DMA};
         end
         (state == ST_OWN1): begin
            if (req1 && (!req0 || !cap))
               gnt = '{valid: 1'b1, port: PORT_DMA};
            else if (req0)
               gnt = '{valid: 1'b1, port: PORT_CPU};
         end
         default: begin
            // Idle tie goes to whoever was not served last.
            if (req0 && req1)
               gnt = '{valid: 1'b1, port: !last};
            else if (req0 || req1)
               gnt = '{valid: 1'b1, port: req1};
         end
      endcase
   end

   assign kept = gnt.valid && (state == own_state(gnt.port));

   always_comb begin
      state_nx = ST_IDLE;
      count_nx = '0;
      if (gnt.valid) begin
         state_nx = own_state(gnt.port);
         if (!kept)
            count_nx = CNT_W'(1);
         else if (cap)
            count_nx = MAXC;
         else
            count_nx = count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_data_arbiter.sv
// Two-port round-robin arbiter in front of the data memory
// with bounded bursts and registered read return.
module mem_data_arbiter
   import mem_data_arbiter_pkg::*;
#(
   parameter int AW         = ARB_AW,
   parameter int DW         = ARB_DW,
   parameter int MAX_BURST  = 4,
   parameter int FIRST_PORT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [AW-1:0]        addr0,
   input  logic [AW-1:0]        addr1,
   input  logic signed [DW-1:0] wdata0,
   input  logic signed [DW-1:0] wdata1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 rvalid0,
   output logic                 rvalid1,
   output logic signed [DW-1:0] rdata0,
   output logic signed [DW-1:0] rdata1,
   output logic                 mem_wr,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_wdata,
   input  logic [DW-1:0]        mem_rdata
);

   localparam logic LAST_RST = (FIRST_PORT == 0);

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nx;
   logic             last;
   grant_t           pick;
   logic             rd0;
   logic             rd1;

   mem_arb_rr_pick #(
      .MAX_BURST (MAX_BURST)
   ) u_pick (
      .state    (state),
      .count    (count),
      .last     (last),
      .req0     (req0),
      .req1     (req1),
      .gnt      (pick),
      .state_nx (state_nx),
      .count_nx (count_nx)
   );

   // Grants are gated so nothing reaches memory during reset.
   assign gnt0 = rst_n && pick.valid && (pick.port == PORT_CPU);
   assign gnt1 = rst_n && pick.valid && (pick.port == PORT_DMA);

   assign mem_wr = (gnt0 && we0) || (gnt1 && we1);

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst_n) begin
         mem_addr  = gnt1 ? addr1 : addr0;
         mem_wdata = gnt1 ? wdata1 : wdata0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         count <= '0;
         last  <= LAST_RST;
      end else begin
         state <= state_nx;
         count <= count_nx;
         if (pick.valid)
            last <= pick.port;
      end
   end

   assign rd0 = gnt0 && !we0;
   assign rd1 = gnt1 && !we1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= rd0;
         rvalid1 <= rd1;
         if (rd0)
            rdata0 <= mem_rdata;
         if (rd1)
            rdata1 <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Self-checking bench for mem_data_arbiter with an
// attached 256x32 memory and a behavioural reference model.
module tb_mem_data_arbiter;

   localparam int MAXB = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               req0 = 1'b0, req1 = 1'b0;
   logic               we0 = 1'b0, we1 = 1'b0;
   logic [7:0]         addr0 = '0, addr1 = '0;
   logic signed [31:0] wdata0 = '0, wdata1 = '0;
   logic               gnt0, gnt1, rvalid0, rvalid1;
   logic signed [31:0] rdata0, rdata1;
   logic               mem_wr;
   logic [7:0]         mem_addr;
   logic [31:0]        mem_wdata, mem_rdata;

   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];

   int vec = 0;
   int errs = 0;

   int m_own = -1;
   int m_cnt = 0;
   int m_last = 1;
   logic        e_rv0 = 0, e_rv1 = 0;
   logic [31:0] e_rd0 = '0, e_rd1 = '0;
   logic        s_g0, s_g1;

   mem_data_arbiter #(
      .AW(8), .DW(32), .MAX_BURST(MAXB), .FIRST_PORT(0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk)
      if (mem_wr) mem[mem_addr] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      if (!req0 && !req1) return -1;
      if (req0 && !req1) return 0;
      if (req1 && !req0) return 1;
      if (m_own < 0) return 1 - m_last;
      if (m_cnt < MAXB) return m_own;
      return 1 - m_own;
   endfunction

   task automatic model_reset();
      m_own = -1; m_cnt = 0; m_last = 1;
      e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
   endtask

   // One clock: check combinational outputs mid-cycle,
   // then the registered read return after the edge.
   task automatic step(output int g);
      logic ew;
      @(negedge clk);
      g = pick();
      s_g0 = gnt0;
      s_g1 = gnt1;
      chk("gnt0", gnt0, g == 0);
      chk("gnt1", gnt1, g == 1);
      ew = (g == 0 && we0) || (g == 1 && we1);
      chk("mem_wr", mem_wr, ew);
      chk("mem_addr", mem_addr, (g == 1) ? addr1 : addr0);
      if (ew) chk("mem_wdata", mem_wdata, (g == 1) ? wdata1 : wdata0);
      e_rv0 = (g == 0) && !we0;
      e_rv1 = (g == 1) && !we1;
      if (e_rv0) e_rd0 = ref_mem[addr0];
      if (e_rv1) e_rd1 = ref_mem[addr1];
      if (g == 0 && we0) ref_mem[addr0] = wdata0;
      if (g == 1 && we1) ref_mem[addr1] = wdata1;
      if (g < 0) begin
         m_own = -1; m_cnt = 0;
      end else begin
         m_cnt = (g == m_own) ? ((m_cnt < MAXB) ? m_cnt + 1 : MAXB) : 1;
         m_own = g;
         m_last = g;
      end
      @(posedge clk);
      #1;
      chk("rvalid0", rvalid0, e_rv0);
      chk("rvalid1", rvalid1, e_rv1);
      chk("rdata0", rdata0, e_rd0);
      chk("rdata1", rdata1, e_rd1);
   endtask

   initial begin
      int g;
      logic [31:0] old20;
      int exp_seq [12] = '{0,0,0,0,1,1,1,1,0,0,0,0};
      bit p0, p1;
      int w0, w1;

      for (int i = 0; i < 256; i++) begin
         logic [31:0] v;
         v = $urandom;
         mem[i] <= v;
         ref_mem[i] = v;
      end

      // Reset: outputs quiet even with a request present.
      req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 32'h0000_00AA;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt0", gnt0, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rdata0", rdata0, 0);
      model_reset();

      rst_n = 1;
      step(g);
      chk("first_write_gnt0", s_g0, 1);
      we0 = 0;
      step(g);
      chk("read_back_aa", rdata0, 32'h0000_00AA);
      req0 = 0;
      step(g);

      // DMA writes -1, CPU reads it on the next cycle.
      req1 = 1; we1 = 1; addr1 = 8'hFF; wdata1 = 32'hFFFF_FFFF;
      step(g);
      req1 = 0; req0 = 1; we0 = 0; addr0 = 8'hFF;
      step(g);
      chk("raw_ff", rdata0, 32'hFFFF_FFFF);
      req0 = 0;
      step(g);

      // Uncontended stream is never capped.
      for (int i = 0; i < 10; i++) begin
         req0 = 1; we0 = 0; addr0 = 8'(i);
         step(g);
         chk("stream_gnt0", s_g0, 1);
      end
      req0 = 0;
      step(g);

      // Owner drops its request mid-burst: no bubble.
      req0 = 1; addr0 = 8'h01;
      step(g);
      req1 = 1; we1 = 0; addr1 = 8'h02; addr0 = 8'h03;
      step(g);
      req0 = 0;
      step(g);
      chk("handover_gnt1", s_g1, 1);
      req0 = 1; addr0 = 8'h04;
      for (int i = 0; i < 4; i++) step(g);
      chk("restart_burst_switch", s_g0, 1);
      req0 = 0; req1 = 0;
      step(g);

      // Reset hits with a DMA write pending and a CPU rvalid due.
      req0 = 1; we0 = 0; addr0 = 8'h03;
      step(g);
      addr0 = 8'h04;
      req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 32'h1234_5678;
      step(g);
      chk("pend_rvalid0", rvalid0, 1);
      old20 = mem[8'h20];
      rst_n = 0;
      #1;
      chk("mid_rst_gnt0", gnt0, 0);
      chk("mid_rst_gnt1", gnt1, 0);
      chk("mid_rst_mem_wr", mem_wr, 0);
      chk("mid_rst_rvalid0", rvalid0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem20", mem[8'h20], old20);
      rst_n = 1;

      // Both held after release: FIRST_PORT wins, then bursts.
      for (int i = 0; i < 12; i++) begin
         step(g);
         chk("burst_seq", s_g1, exp_seq[i]);
         if (s_g1) begin we1 = 0; addr1 = 8'($urandom_range(15)); end
         if (s_g0) addr0 = 8'($urandom_range(15));
      end
      req0 = 0; req1 = 0;
      step(g);

      // Random traffic honouring the hold-until-granted handshake.
      p0 = 0; p1 = 0; w0 = 0; w1 = 0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && $urandom_range(2) != 0) begin
            p0 = 1; we0 = $urandom_range(1);
            addr0 = 8'($urandom_range(15)); wdata0 = $urandom;
         end
         if (!p1 && $urandom_range(2) != 0) begin
            p1 = 1; we1 = $urandom_range(1);
            addr1 = 8'($urandom_range(15)); wdata1 = $urandom;
         end
         req0 = p0; req1 = p1;
         step(g);
         if (p0) begin
            if (s_g0) begin
               chk("wait0_bound", w0 <= MAXB, 1);
               p0 = 0; w0 = 0;
            end else w0++;
         end
         if (p1) begin
            if (s_g1) begin
               chk("wait1_bound", w1 <= MAXB, 1);
               p1 = 0; w1 = 0;
            end else w1++;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
